// File: rtl/branch_seq_pkg.sv
// Shared definitions for the branch sequencer: FSM states, IR field positions, C2 codes.
package branch_seq_pkg;

  localparam int unsigned IR_C2_HI    = 20;
  localparam int unsigned IR_C2_LO    = 19;
  localparam int unsigned IR_LINK_BIT = 27;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COND = 2'd1,
    ST_TGT  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Condition selector carried to the downstream condition flip-flop.
  typedef enum logic [1:0] {
    C2_ZERO    = 2'b00,
    C2_NONZERO = 2'b01,
    C2_POS     = 2'b10,
    C2_NEG     = 2'b11
  } c2_e;

endpackage

// File: rtl/branch_seq_pc_register.sv
// Program counter with synchronous load/increment (load has priority) and async clear.
module pc_register #(
  parameter int unsigned BITS = 32
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            load,
  input  logic            inc,
  input  logic [BITS-1:0] load_val,
  output logic [BITS-1:0] pc
);

  logic [BITS-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/branch_seq.sv
// Branch sequencer: resolves a conditional branch in IDLE->COND->TGT->DONE, owns the PC.
// BITS must be at least IR_LINK_BIT+1 so the IR fields exist.
module branch_seq
  import branch_seq_pkg::*;
#(
  parameter int unsigned BITS = 32
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            start,
  input  logic [BITS-1:0] ir,
  input  logic [BITS-1:0] bus_in,
  input  logic            con_q,
  input  logic            inc_pc,
  output logic            con_enable,
  output logic [1:0]      ir_c2,
  output logic [BITS-1:0] pc_out,
  output logic            link_wr,
  output logic [BITS-1:0] link_data,
  output logic            busy,
  output logic            done
);

  state_e          state_q, state_d;
  logic [1:0]      ir_c2_q, ir_c2_d;
  logic            link_q, link_d;
  logic            taken_q, taken_d;
  logic            con_enable_q, con_enable_d;
  logic            link_wr_q, link_wr_d;
  logic [BITS-1:0] link_data_q, link_data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pc_load, pc_inc;
  logic            unused_ir;

  assign unused_ir = ^ir;

  pc_register #(.BITS(BITS)) u_pc (
    .clk      (clk),
    .clr_n    (clr_n),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (bus_in),
    .pc       (pc_out)
  );

  // Next state; registered outputs are computed for the state being entered.
  always_comb begin
    state_d      = state_q;
    ir_c2_d      = ir_c2_q;
    link_d       = link_q;
    taken_d      = taken_q;
    con_enable_d = 1'b0;
    link_wr_d    = 1'b0;
    link_data_d  = link_data_q;
    done_d       = 1'b0;
    pc_load      = 1'b0;
    pc_inc       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_COND;
          ir_c2_d      = ir[IR_C2_HI:IR_C2_LO];
          link_d       = ir[IR_LINK_BIT];
          taken_d      = 1'b0;
          con_enable_d = 1'b1;
        end else if (inc_pc) begin
          pc_inc = 1'b1;
        end
      end
      ST_COND: begin
        state_d = ST_TGT;
        taken_d = con_q;
        // PC cannot move during COND, so this is the pre-branch value seen in TGT.
        if (link_q) begin
          link_wr_d   = 1'b1;
          link_data_d = pc_out;
        end
      end
      ST_TGT: begin
        state_d = ST_DONE;
        pc_load = taken_q;
        done_d  = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= ST_IDLE;
      ir_c2_q      <= 2'b00;
      link_q       <= 1'b0;
      taken_q      <= 1'b0;
      con_enable_q <= 1'b0;
      link_wr_q    <= 1'b0;
      link_data_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_c2_q      <= ir_c2_d;
      link_q       <= link_d;
      taken_q      <= taken_d;
      con_enable_q <= con_enable_d;
      link_wr_q    <= link_wr_d;
      link_data_q  <= link_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign con_enable = con_enable_q;
  assign ir_c2      = ir_c2_q;
  assign link_wr    = link_wr_q;
  assign link_data  = link_data_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_branch_seq.sv
// Self-checking bench for branch_seq: directed scenarios plus randomized branch/increment traffic.
module tb_branch_seq;

  localparam int unsigned BITS = 32;

  logic            clk = 1'b0;
  logic            clr_n;
  logic            start;
  logic [BITS-1:0] ir;
  logic [BITS-1:0] bus_in;
  logic            con_q;
  logic            inc_pc;
  logic            con_enable;
  logic [1:0]      ir_c2;
  logic [BITS-1:0] pc_out;
  logic            link_wr;
  logic [BITS-1:0] link_data;
  logic            busy;
  logic            done;

  int vectors     = 0;
  int miscompares = 0;
  logic [BITS-1:0] model_pc;

  always #5 clk = ~clk;

  branch_seq #(.BITS(BITS)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .start      (start),
    .ir         (ir),
    .bus_in     (bus_in),
    .con_q      (con_q),
    .inc_pc     (inc_pc),
    .con_enable (con_enable),
    .ir_c2      (ir_c2),
    .pc_out     (pc_out),
    .link_wr    (link_wr),
    .link_data  (link_data),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".pc"}, pc_out, model_pc);
  endtask

  task automatic do_inc(input int n);
    for (int i = 0; i < n; i++) begin
      start  = 1'b0;
      inc_pc = 1'b1;
      step();
      model_pc = model_pc + 32'd1;
      check("inc.pc", pc_out, model_pc);
    end
    inc_pc = 1'b0;
  endtask

  // Full branch; noise drives start/inc_pc while busy to confirm they are ignored.
  task automatic do_branch(input logic [31:0] ir_val, input logic con, input logic [31:0] tgt,
                           input logic [31:0] cond_bus, input logic inc_with_start,
                           input logic noise);
    logic [31:0] pc_before;
    logic        lnk;
    pc_before = model_pc;
    lnk       = ir_val[27];
    start  = 1'b1;
    ir     = ir_val;
    inc_pc = inc_with_start;
    step();
    check("cond.con_enable", 32'(con_enable), 32'd1);
    check("cond.busy", 32'(busy), 32'd1);
    check("cond.ir_c2", 32'(ir_c2), 32'(ir_val[20:19]));
    check("cond.pc", pc_out, pc_before);
    check("cond.link_wr", 32'(link_wr), 32'd0);
    start  = noise;
    inc_pc = noise;
    ir     = ~ir_val;
    con_q  = con;
    bus_in = cond_bus;
    step();
    check("tgt.con_enable", 32'(con_enable), 32'd0);
    check("tgt.link_wr", 32'(link_wr), 32'(lnk));
    if (lnk) check("tgt.link_data", link_data, pc_before);
    check("tgt.ir_c2", 32'(ir_c2), 32'(ir_val[20:19]));
    check("tgt.pc", pc_out, pc_before);
    check("tgt.done", 32'(done), 32'd0);
    con_q  = ~con;
    bus_in = tgt;
    step();
    if (con) model_pc = tgt;
    check("done.done", 32'(done), 32'd1);
    check("done.busy", 32'(busy), 32'd1);
    check("done.link_wr", 32'(link_wr), 32'd0);
    check("done.pc", pc_out, model_pc);
    bus_in = 32'hdead_beef;
    step();
    start  = 1'b0;
    inc_pc = 1'b0;
    check_idle("idle_after");
  endtask

  function automatic logic [31:0] make_ir(input logic [1:0] c2, input logic lnk);
    logic [31:0] r;
    r = $urandom & ~32'h0818_0000;
    r = r | (32'(c2) << 19) | (32'(lnk) << 27);
    return r;
  endfunction

  initial begin
    clr_n  = 1'b0;
    start  = 1'b0;
    ir     = '0;
    bus_in = '0;
    con_q  = 1'b0;
    inc_pc = 1'b0;
    model_pc = '0;
    step();
    step();
    check("rst.pc", pc_out, 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.ir_c2", 32'(ir_c2), 32'd0);
    check("rst.link_data", link_data, 32'd0);
    check("rst.flags", {29'd0, con_enable, link_wr, done}, 32'd0);
    clr_n = 1'b1;

    do_inc(3);

    // Reach 0x10, then a taken C2=00 branch to 0x200.
    do_branch(make_ir(2'b00, 1'b0), 1'b1, 32'h10, 32'h0, 1'b0, 1'b0);
    do_branch(make_ir(2'b00, 1'b0), 1'b1, 32'h200, 32'h0, 1'b0, 1'b0);
    // Back to 0x10, then a not-taken C2=01 branch.
    do_branch(make_ir(2'b11, 1'b0), 1'b1, 32'h10, 32'h0, 1'b0, 1'b1);
    do_branch(make_ir(2'b01, 1'b0), 1'b0, 32'h200, 32'h0, 1'b0, 1'b0);
    // Linked taken branch from 0x40.
    do_branch(make_ir(2'b10, 1'b0), 1'b1, 32'h40, $urandom, 1'b0, 1'b0);
    do_branch(make_ir(2'b10, 1'b1), 1'b1, 32'h1234_5678, $urandom, 1'b0, 1'b1);
    // Linked not-taken still writes the link.
    do_branch(make_ir(2'b01, 1'b1), 1'b0, 32'h0bad_0bad, $urandom, 1'b0, 1'b1);
    // start beats inc_pc at the wrap boundary, then a lone inc wraps to zero.
    do_branch(make_ir(2'b00, 1'b0), 1'b1, 32'hffff_ffff, 32'h0, 1'b0, 1'b0);
    do_branch(make_ir(2'b00, 1'b0), 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("wrap.pre", pc_out, 32'hffff_ffff);
    do_inc(1);
    check("wrap.zero", pc_out, 32'h0);

    // Asynchronous clear in the TGT cycle.
    do_inc(2);
    start = 1'b1;
    ir    = make_ir(2'b10, 1'b1);
    step();
    start  = 1'b0;
    con_q  = 1'b1;
    bus_in = 32'h777;
    step();
    check("midrst.in_tgt", 32'(busy), 32'd1);
    clr_n = 1'b0;
    #1;
    model_pc = '0;
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.pc", pc_out, 32'd0);
    check("midrst.flags", {29'd0, con_enable, link_wr, done}, 32'd0);
    check("midrst.ir_c2", 32'(ir_c2), 32'd0);
    check("midrst.link_data", link_data, 32'd0);
    @(negedge clk);
    check("midrst.hold_done", 32'(done), 32'd0);
    clr_n = 1'b1;
    step();
    check_idle("midrst.after");
    do_branch(make_ir(2'b01, 1'b0), 1'b1, 32'h55, $urandom, 1'b0, 1'b0);

    // Randomized traffic against the model.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_inc(int'($urandom_range(1, 4)));
      end else begin
        do_branch(make_ir(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1))),
                  1'($urandom_range(0, 1)), $urandom, $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
